bcd_converter: RTL

BCD_CONVERTER -- requirements
Module: bcd_converter

---
 rtl/bcd_converter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter: 32-bit operand to 8 packed BCD digits.
// Define BCD_SIGNED_EN to treat iBin as two's complement and report the sign on oNeg.
module bcd_converter (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [31:0] iBin,
    input  logic        iStart,
    output logic [31:0] oBcd,
    output logic        oBusy,
    output logic        oDone,
    output logic        oOverflow,
    output logic        oNeg
);

    localparam int unsigned BIN_W  = 32;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned DIGITS = 10;
    localparam int unsigned ACC_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = 6;

    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(BIN_W);
    localparam logic [OUT_W-1:0] OVF_PATTERN = 32'hEEEE_EEEE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [BIN_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [OUT_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BIN_W-1:0]   mag_c;
    logic               sign_c;
    logic [ACC_W-1:0]   acc_adj_c;

    // Add 3 to every digit >= 5 so the following left shift carries correctly into the next digit.
    function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef BCD_SIGNED_EN
    assign sign_c = iBin[BIN_W-1];
    assign mag_c  = iBin[BIN_W-1] ? (~iBin + BIN_W'(1)) : iBin;
`else
    assign sign_c = 1'b0;
    assign mag_c  = iBin;
`endif

    assign acc_adj_c = add3(acc_q);

    // State and datapath registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath; results only change on the SHIFT -> DONE transition.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (iStart) begin
                    state_d = SHIFT;
                    op_d    = mag_c;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sign_d  = sign_c;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    ovf_d   = |acc_q[ACC_W-1:OUT_W];
                    bcd_d   = ovf_d ? OVF_PATTERN : acc_q[OUT_W-1:0];
                    neg_d   = sign_q;
                end else begin
                    acc_d = {acc_adj_c[ACC_W-2:0], op_q[BIN_W-1]};
                    op_d  = {op_q[BIN_W-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    assign oBcd      = bcd_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oOverflow = ovf_q;
    assign oNeg      = neg_q;

endmodule
